// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: FSM states and configuration helpers shared by the pattern detector
package seq_detector_pkg;
  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;
  function automatic logic [63:0] len_mask(int len);
    return len >= 64 ? '1 : (64'd1 << len) - 64'd1;
  endfunction
  function automatic int clamp_len(int len, int max_len);
    return len > max_len ? max_len : len;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk or negedge reset_i)
    if (!reset_i) cnt_o <= '0;
    else if (clr_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable serial pattern detector; match counter built only under SEQDET_MATCH_CNT_EN
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               in_valid_i,
  input  logic               in_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  input  logic               clear_i,
  output logic               detected_o,
  output logic [CNT_W-1:0]   match_cnt_o
);
  state_t state, state_n;
  logic [MAX_LEN-1:0] cfg_pat, pat_n, hist, hist_n, hist_sh, mask;
  logic [LEN_W-1:0] cfg_len, len_n, new_len, fill, fill_n, fill_inc;
  logic cfg_ovl, ovl_n, match, flush, acc, det_n;
  always_comb begin
    hist_sh = MAX_LEN'({hist, in_i});
    fill_inc = fill == cfg_len ? fill : fill + 1'b1;
    mask = MAX_LEN'(len_mask(int'(cfg_len)));
    match = in_valid_i && state != IDLE && fill_inc == cfg_len && ((hist_sh ^ cfg_pat) & mask) == '0;
    new_len = LEN_W'(clamp_len(int'(len_i), MAX_LEN));
    pat_n = cfg_load_i ? pattern_i : cfg_pat;
    len_n = cfg_load_i ? new_len : cfg_len;
    ovl_n = cfg_load_i ? overlap_i : cfg_ovl;
    flush = cfg_load_i || clear_i;
    acc = in_valid_i && !flush;
    det_n = acc && match;
    hist_n = flush ? '0 : acc ? hist_sh : hist;
    fill_n = flush || (det_n && !cfg_ovl) ? '0 : acc ? fill_inc : fill;
    state_n = cfg_load_i ? (new_len == '0 ? IDLE : FILL)
            : state == IDLE ? IDLE
            : clear_i || (det_n && !cfg_ovl) ? FILL
            : acc && fill_inc == cfg_len ? ARMED : state;
  end
  always_ff @(posedge clk or negedge reset_i)
    if (!reset_i) begin
      state <= IDLE;
      cfg_pat <= '0;
      cfg_len <= '0;
      cfg_ovl <= 1'b0;
      hist <= '0;
      fill <= '0;
      detected_o <= 1'b0;
    end else begin
      state <= state_n;
      cfg_pat <= pat_n;
      cfg_len <= len_n;
      cfg_ovl <= ovl_n;
      hist <= hist_n;
      fill <= fill_n;
      detected_o <= det_n;
    end
`ifdef SEQDET_MATCH_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .reset_i(reset_i), .clr_i(clear_i && !cfg_load_i), .inc_i(det_n), .cnt_o(match_cnt_o)
  );
`else
  assign match_cnt_o = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: vector table, corner sequences and random stream against a queue-based model
module tb_seq_detector_param;
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, din = 1'b0, load = 1'b0, ovl = 1'b0, clr = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] len = '0;
  logic det, det2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset_i(rst_n), .in_valid_i(valid), .in_i(din), .cfg_load_i(load),
    .pattern_i(pat), .len_i(len), .overlap_i(ovl), .clear_i(clr),
    .detected_o(det), .match_cnt_o(cnt));
  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_i(rst_n), .in_valid_i(valid), .in_i(din), .cfg_load_i(load),
    .pattern_i(pat), .len_i(len), .overlap_i(ovl), .clear_i(clr),
    .detected_o(det2), .match_cnt_o(cnt2));
  int m_len = 0, m_cnt = 0, m_cnt2 = 0;
  logic [7:0] m_pat = '0;
  logic m_ovl = 1'b0, m_det = 1'b0;
  bit q[$];
  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_len = 0; m_pat = '0; m_ovl = 1'b0; m_det = 1'b0; m_cnt = 0; m_cnt2 = 0;
    q.delete();
  endfunction
  function automatic void model_step(bit v, bit b, bit ld, bit c);
    bit hit;
    m_det = 1'b0;
    if (ld) begin
      m_len = len > 8 ? 8 : int'(len); m_pat = pat; m_ovl = ovl;
      q.delete();
    end else if (c) begin
      q.delete(); m_cnt = 0; m_cnt2 = 0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > m_len) void'(q.pop_front());
      if (m_len > 0 && q.size() == m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) if (q[i] != m_pat[m_len-1-i]) hit = 1'b0;
        if (hit) begin
          m_det = 1'b1;
          m_cnt = m_cnt == 65535 ? m_cnt : m_cnt + 1;
          m_cnt2 = m_cnt2 == 3 ? 3 : m_cnt2 + 1;
          if (!m_ovl) q.delete();
        end
      end
    end
  endfunction
  task automatic step(bit v, bit b, bit ld, bit c);
    valid = v; din = b; load = ld; clr = c;
    @(posedge clk);
    model_step(v, b, ld, c);
    #1;
    chk("model_det", int'(det), int'(m_det));
    chk("model_det2", int'(det2), int'(m_det));
    chk("model_cnt", int'(cnt), CNT_ON ? m_cnt : 0);
    chk("model_cnt2", int'(cnt2), CNT_ON ? m_cnt2 : 0);
  endtask
  typedef struct {
    bit v, b, ld, c;
    logic [7:0] pat;
    logic [3:0] len;
    bit ovl, det;
    int cnt;
  } vec_t;
  vec_t tbl[$];
  initial begin
    logic [3:0] gp;
    logic [7:0] a5;
    #1;
    chk("rst_det", int'(det), 0);
    chk("rst_cnt", int'(cnt), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    tbl.push_back('{0,0,1,0,8'h0B,4,1,0,0});
    tbl.push_back('{1,1,0,0,8'h0B,4,1,0,0});
    tbl.push_back('{1,0,0,0,8'h0B,4,1,0,0});
    tbl.push_back('{1,1,0,0,8'h0B,4,1,0,0});
    tbl.push_back('{1,1,0,0,8'h0B,4,1,1,1});
    tbl.push_back('{1,0,0,0,8'h0B,4,1,0,1});
    tbl.push_back('{1,1,0,0,8'h0B,4,1,0,1});
    tbl.push_back('{1,1,0,0,8'h0B,4,1,1,2});
    tbl.push_back('{0,0,1,0,8'h0B,4,0,0,2});
    tbl.push_back('{1,1,0,0,8'h0B,4,0,0,2});
    tbl.push_back('{1,0,0,0,8'h0B,4,0,0,2});
    tbl.push_back('{1,1,0,0,8'h0B,4,0,0,2});
    tbl.push_back('{1,1,0,0,8'h0B,4,0,1,3});
    tbl.push_back('{1,0,0,0,8'h0B,4,0,0,3});
    tbl.push_back('{1,1,0,0,8'h0B,4,0,0,3});
    tbl.push_back('{1,1,0,0,8'h0B,4,0,0,3});
    tbl.push_back('{0,0,0,1,8'h0B,4,0,0,0});
    foreach (tbl[i]) begin
      pat = tbl[i].pat; len = tbl[i].len; ovl = tbl[i].ovl;
      step(tbl[i].v, tbl[i].b, tbl[i].ld, tbl[i].c);
      chk($sformatf("tbl%0d_det", i), int'(det), int'(tbl[i].det));
      chk($sformatf("tbl%0d_cnt", i), int'(cnt), CNT_ON ? tbl[i].cnt : 0);
    end
    gp = 4'b1011; pat = 8'h0B; len = 4; ovl = 1'b1;
    step(0, 0, 1, 0);
    for (int i = 3; i >= 0; i--) begin
      step(1, gp[i], 0, 0);
      chk("gap_det", int'(det), i == 0 ? 1 : 0);
      repeat (3) begin
        step(0, 0, 0, 0);
        chk("gap_idle", int'(det), 0);
      end
    end
    pat = 8'h01; len = 1; ovl = 1'b0;
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 0, 0);
      chk("sat_det", int'(det2), 1);
      chk("sat_cnt2", int'(cnt2), CNT_ON ? (k < 3 ? k : 3) : 0);
    end
    a5 = 8'hA5; pat = 8'hA5; len = 12; ovl = 1'b0;
    step(1, 1, 1, 0);
    for (int i = 6; i >= 0; i--) begin
      step(1, a5[i], 0, 0);
      chk("clamp_drop", int'(det), 0);
    end
    for (int i = 7; i >= 0; i--) begin
      step(1, a5[i], 0, 0);
      chk("clamp_det", int'(det), i == 0 ? 1 : 0);
    end
    pat = 8'h0B; len = 4; ovl = 1'b1;
    step(0, 0, 1, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("pre_rst_det", int'(det), 1);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("pre_rst_det2", int'(det), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_det", int'(det), 0);
    chk("async_rst_cnt", int'(cnt), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("post_rst_det", int'(det), 0);
    pat = 8'($urandom); len = 3; ovl = 1'b1;
    step(0, 0, 1, 0);
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pat = 8'($urandom); len = 4'($urandom_range(0, 10)); ovl = 1'($urandom);
        step(1'($urandom), 1'($urandom), 1, 0);
      end else if (r < 5) step(1'($urandom), 1'($urandom), 0, 1);
      else step($urandom_range(0, 9) < 7, 1'($urandom), 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
